timed_count_reader: RTL and testbench

Consumer end of the timed-counter output stream. Captures each `count_in`/`count_in_valid` sample produced by `dsp_timed_counter`, tags it with an 8-bit sequence number and buffers it in a small FIFO. Samples are presented on an AXI4-Stream-style master port to a register or readout path. Samples that arrive while the buffer is full are dropped and counted, so the downstream reader can detect loss from both the drop counter and gaps in the sequence number.

---
 rtl/timed_count_reader.sv | 110 +++++++++++
 tb/tb_timed_count_reader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/timed_count_reader.sv
// Timed-counter sample reader: tags each strobed sample with an 8-bit sequence number, buffers it in a FIFO and drops/counts samples when full.
// Optional feature macro: TIMED_COUNT_READER_PEAK_EN adds an unsigned running-maximum register (peak_out/peak_clear).
module timed_count_reader #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] count_in,
  input  logic             count_in_valid,
  output logic [WIDTH-1:0] m_tdata,
  output logic [7:0]       m_tuser,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [15:0]      drop_count,
  input  logic             drop_clear
`ifdef TIMED_COUNT_READER_PEAK_EN
  ,
  output logic [WIDTH-1:0] peak_out,
  input  logic             peak_clear
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;
  localparam int EW = WIDTH + 8;

  logic [EW-1:0] mem [0:DEPTH-1];
  logic [PW-1:0] wptr, rptr, wptr_nxt, rptr_nxt;
  logic [7:0]    seq;
  logic          full, pop, push, drop;
  logic          valid_nxt;
  logic [EW-1:0] wr_entry, head_nxt;

  assign full     = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign pop      = m_tvalid & m_tready;
  assign push     = count_in_valid & (~full | pop);
  assign drop     = count_in_valid & full & ~pop;
  assign wr_entry = {seq, count_in};
  assign wptr_nxt = wptr + PW'(push);
  assign rptr_nxt = rptr + PW'(pop);
  assign valid_nxt = (rptr_nxt != wptr_nxt);

  // The output stage is loaded with the post-edge head; when that head is the
  // entry being written this edge, it is taken from the write data instead.
  always_comb begin
    head_nxt = mem[rptr_nxt[AW-1:0]];
    if (push && (rptr_nxt == wptr)) begin
      head_nxt = wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr[AW-1:0]] <= wr_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      seq      <= '0;
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tuser  <= '0;
    end else begin
      wptr     <= wptr_nxt;
      rptr     <= rptr_nxt;
      m_tvalid <= valid_nxt;
      if (count_in_valid) begin
        seq <= seq + 8'd1;
      end
      if (valid_nxt) begin
        {m_tuser, m_tdata} <= head_nxt;
      end
    end
  end

  // A clear coinciding with a drop keeps that drop counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (drop) begin
      if (drop_clear) begin
        drop_count <= 16'd1;
      end else if (drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end
    end else if (drop_clear) begin
      drop_count <= '0;
    end
  end

`ifdef TIMED_COUNT_READER_PEAK_EN
  // Peak tracks every strobed sample, accepted or dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_out <= '0;
    end else if (count_in_valid) begin
      if (peak_clear || (count_in > peak_out)) begin
        peak_out <= count_in;
      end
    end else if (peak_clear) begin
      peak_out <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_timed_count_reader.sv
// Scoreboard bench for timed_count_reader: queue-based reference model, randomized and directed stimulus.
module tb_timed_count_reader;
  localparam int WIDTH = 24;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] count_in = '0;
  logic             count_in_valid = 1'b0;
  logic [WIDTH-1:0] m_tdata;
  logic [7:0]       m_tuser;
  logic             m_tvalid;
  logic             m_tready = 1'b0;
  logic [15:0]      drop_count;
  logic             drop_clear = 1'b0;
`ifdef TIMED_COUNT_READER_PEAK_EN
  logic [WIDTH-1:0] peak_out;
  logic             peak_clear = 1'b0;
`endif

  timed_count_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .count_in(count_in), .count_in_valid(count_in_valid),
    .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .drop_count(drop_count), .drop_clear(drop_clear)
`ifdef TIMED_COUNT_READER_PEAK_EN
    , .peak_out(peak_out), .peak_clear(peak_clear)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model state: everything below is the value after the last applied edge.
  logic [WIDTH+7:0] exp_q[$];
  int               occ = 0;
  logic [7:0]       seq_m = 0;
  int               drop_m = 0;
  logic [WIDTH-1:0] peak_m = 0;
  logic [WIDTH+7:0] last_rd = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshake must deliver the oldest accepted sample.
  always @(negedge clk) begin
    if (rst_n && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {8'h0, m_tuser, m_tdata}, 32'hDEAD_BEEF);
      end else begin
        last_rd = exp_q.pop_front();
        chk("head_entry", {8'h0, m_tuser, m_tdata}, {8'h0, last_rd});
      end
    end
  end

  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r,
                      input logic dc, input logic pc);
    bit p_pop, p_push, p_drop;
    @(posedge clk);
    #1;
    chk("tvalid", {31'h0, m_tvalid}, {31'h0, (occ > 0)});
    chk("drop_count", {16'h0, drop_count}, drop_m);
`ifdef TIMED_COUNT_READER_PEAK_EN
    chk("peak", {8'h0, peak_out}, {8'h0, peak_m});
    peak_clear = pc;
    if (v) peak_m = (pc || d > peak_m) ? d : peak_m;
    else if (pc) peak_m = 0;
`endif
    count_in_valid = v;
    count_in       = d;
    m_tready       = r;
    drop_clear     = dc;
    p_pop  = (occ > 0) && r;
    p_push = v && ((occ - int'(p_pop)) < DEPTH);
    p_drop = v && !p_push;
    occ = occ - int'(p_pop) + int'(p_push);
    if (p_push) exp_q.push_back({seq_m, d});
    if (v) seq_m = seq_m + 8'd1;
    if (p_drop) drop_m = dc ? 1 : ((drop_m == 65535) ? 65535 : drop_m + 1);
    else if (dc) drop_m = 0;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    count_in_valid = 1'b0;
    drop_clear = 1'b0;
    m_tready = 1'b0;
`ifdef TIMED_COUNT_READER_PEAK_EN
    peak_clear = 1'b0;
`endif
    #1;
    chk("rst_tvalid", {31'h0, m_tvalid}, 0);
    chk("rst_tdata", {8'h0, m_tdata}, 0);
    chk("rst_tuser", {24'h0, m_tuser}, 0);
    chk("rst_drop", {16'h0, drop_count}, 0);
`ifdef TIMED_COUNT_READER_PEAK_EN
    chk("rst_peak", {8'h0, peak_out}, 0);
    peak_m = 0;
`endif
    exp_q.delete();
    occ = 0;
    seq_m = 0;
    drop_m = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 1, 0, 0);
    chk("drained", exp_q.size(), 0);
  endtask

  initial begin
    do_reset();

    // single sample
    step(1, 50, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("single_data", {8'h0, m_tdata}, 50);
    chk("single_user", {24'h0, m_tuser}, 0);
    step(0, 0, 1, 0, 0);
    chk("single_gone", {31'h0, m_tvalid}, 0);

    // overflow
    do_reset();
    for (int i = 1; i <= 6; i++) step(1, WIDTH'(i), 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("ovf_drop", {16'h0, drop_count}, 2);
    chk("ovf_head", {8'h0, m_tuser, m_tdata}, {16'h0, 8'h01});
    drain();
    step(1, 123, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("ovf_next_seq", {24'h0, m_tuser}, 6);
    drain();

    // full with simultaneous push and pop
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, WIDTH'(10 + i), 0, 0, 0);
    step(1, 99, 1, 0, 0);
    drain();
    chk("fullpp_drop", {16'h0, drop_count}, 0);
    chk("fullpp_last", {8'h0, last_rd}, {8'h0, 8'd4, 24'd99});

    // mid-burst reset
    do_reset();
    for (int i = 0; i < 3; i++) step(1, WIDTH'(200 + i), 0, 0, 0);
    step(0, 0, 0, 0, 0);
    do_reset();
    step(1, 77, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("post_rst_user", {24'h0, m_tuser}, 0);
    chk("post_rst_data", {8'h0, m_tdata}, 77);
    drain();

    // drop clear races and saturation
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, WIDTH'(i), 0, 0, 0);
    step(1, 5, 0, 0, 0);
    step(1, 6, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("clr_race", {16'h0, drop_count}, 1);
    for (int i = 0; i < 65540; i++) step(1, WIDTH'($urandom), 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("drop_sat", {16'h0, drop_count}, 32'h0000_FFFF);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("drop_clr", {16'h0, drop_count}, 0);
    drain();

`ifdef TIMED_COUNT_READER_PEAK_EN
    do_reset();
    step(1, 10, 1, 0, 0);
    step(1, 900, 1, 0, 0);
    step(1, 40, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("peak_max", {8'h0, peak_out}, 900);
    step(1, 7, 1, 0, 1);
    step(0, 0, 1, 0, 0);
    chk("peak_clr_load", {8'h0, peak_out}, 7);
    drain();
`endif

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 60,
           ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 15)) : WIDTH'($urandom),
           $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 3);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
